// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N-to-1 mux channel between N requesters.
// A registered one-hot grant drives the mux select; the owner keeps the
// channel while it requests, bounded to MAX_HOLD cycles under contention.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; grant=0, waiting for any request
// GRANT | one requester owns the channel; hold_cnt counts its tenure
module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int W        = 1,
  parameter int MAX_HOLD = 8,
  parameter int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   d,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic [W-1:0]     f
);

  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N - 1);
  localparam logic [N-1:0]     ONE_HOT0  = N'(1);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic             own_req;
  logic             others;
  logic [N-1:0]     cand;
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] win;
  logic             win_found;

  // Request classification against the current owner; the owner bit is
  // always masked from the candidates so it can never win its own rotation.
  always_comb begin
    own_req = |(req & grant);
    others  = |(req & ~grant);
    cand    = req & ~grant;
    sel_inc = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
    start   = (state == IDLE) ? ptr : sel_inc;
  end

  // First set candidate in circular order beginning at start.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!win_found && cand[idx]) begin
        win       = SEL_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant/sel/valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      sel      <= '0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant    <= ONE_HOT0 << win;
            sel      <= win;
            valid    <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (own_req && (hold_cnt != HOLD_LAST || !others)) begin
            if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HC_W'(1);
          end else begin
            // Release or timeout: pointer moves past the outgoing owner.
            ptr      <= sel_inc;
            hold_cnt <= '0;
            if (win_found) begin
              grant <= ONE_HOT0 << win;
              sel   <= win;
              valid <= 1'b1;
            end else begin
              grant <= '0;
              sel   <= '0;
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          sel   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // Output mux driven by the registered select; zero when nobody owns it.
  always_comb begin
    f = '0;
    if (valid) f = d[sel*W +: W];
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=4, W=4, MAX_HOLD=8).
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 4;
  localparam int MAX_HOLD = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*W-1:0] d;
  logic [N-1:0]  grant;
  logic [1:0]    sel;
  logic          valid;
  logic [W-1:0]  f;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .d     (d),
    .grant (grant),
    .sel   (sel),
    .valid (valid),
    .f     (f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    rst = 1'b1;
    req = 4'b1111;
    d   = {4'hD, 4'hC, 4'hB, 4'hA};

    // Reset holds everything off even with all requests high.
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_sel",   32'(sel),   32'h0);
    check("rst_f",     32'(f),     32'h0);
    rst = 1'b0;
    step();
    check("post_rst_grant", 32'(grant), 32'h1);
    check("post_rst_sel",   32'(sel),   32'h0);
    check("post_rst_f",     32'(f),     32'hA);

    // Owner 0 drops, nobody else -> idle; ptr now 1.
    req = 4'b0000;
    step();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_valid", 32'(valid), 32'h0);

    // Single requester holds indefinitely (beyond MAX_HOLD).
    req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      step();
      check($sformatf("single_c%0d", c), 32'(grant), 32'h4);
    end
    check("single_sel", 32'(sel), 32'h2);
    check("single_f",   32'(f),   32'hC);
    req = 4'b0000;
    step();
    check("single_drop_grant", 32'(grant), 32'h0);
    check("single_drop_f",     32'(f),     32'h0);

    // Round robin with owner dropping for one cycle after each grant.
    pulse_reset();
    req = 4'b1111;
    step();
    check("rr_0", 32'(grant), 32'h1);
    req = 4'b1110;
    step();
    check("rr_1", 32'(grant), 32'h2);
    req = 4'b1101;
    step();
    check("rr_2", 32'(grant), 32'h4);
    req = 4'b1011;
    step();
    check("rr_3", 32'(grant), 32'h8);
    req = 4'b0111;
    step();
    check("rr_wrap", 32'(grant), 32'h1);
    check("rr_wrap_valid", 32'(valid), 32'h1);

    // Timeout rotation under constant contention of requesters 0 and 1.
    pulse_reset();
    req = 4'b0011;
    for (int s = 1; s <= 17; s++) begin
      step();
      exp_g = (((s - 1) / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
      check($sformatf("timeout_s%0d", s), 32'(grant), 32'(exp_g));
    end

    // Owner 0 releases, requester 3 wins; then async reset mid-cycle.
    req = 4'b1000;
    step();
    check("own3_grant", 32'(grant), 32'h8);
    check("own3_f",     32'(f),     32'hD);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_f",     32'(f),     32'h0);
    #2;
    rst = 1'b0;
    step();
    check("after_midrst_grant", 32'(grant), 32'h8);
    check("after_midrst_sel",   32'(sel),   32'h3);

    // Data path: idle forces f=0 regardless of d, owner 1 routes d[7:4].
    req = 4'b0000;
    step();
    check("dp_idle_f", 32'(f), 32'h0);
    d = 16'h5F93;
    #1;
    check("dp_idle_f_newd", 32'(f), 32'h0);
    d = {4'hD, 4'hC, 4'hB, 4'hA};
    req = 4'b0010;
    step();
    check("dp_own1_grant", 32'(grant), 32'h2);
    check("dp_own1_sel",   32'(sel),   32'h1);
    check("dp_own1_f",     32'(f),     32'hB);
    d[7:4] = 4'h5;
    #1;
    check("dp_own1_f_follow", 32'(f), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-to-1 multiplexed output channel between N requesters.
- Drives the mux select from a registered grant and presents the selected requester's data on f.
- A grant is held while its requester keeps req high, up to MAX_HOLD cycles. After that, ownership is forced to rotate if any other requester is waiting.
- Sits between independent sources and a single shared downstream consumer.

Parameters:
- N, 4, number of requesters (2..16).
- W, 1, data width per requester.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others request (>=1).
- SEL_W, $clog2(N), select width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  N  per-requester request, level-sensitive.
- d  input  N*W  packed data; requester k occupies d[k*W +: W].
- grant  output  N  one-hot current owner; all zero when idle.
- sel  output  SEL_W  index of current owner; 0 when idle.
- valid  output  1  high when grant is non-zero.
- f  output  W  d[sel*W +: W] when valid, else all zeros (combinational from registered sel).

Behaviour:
- Reset (async, rst=1): grant=0, sel=0, valid=0, f=0, state=IDLE, ptr=0, hold_cnt=0. Reset asserted mid-grant drops ownership immediately, without waiting for a clock edge.
- ptr is the round-robin priority pointer. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, with modulo-N wrap.
- State IDLE:
  - If req != 0, register winner w = first set bit in search order.
  - Next cycle: grant=1<<w, sel=w, valid=1, hold_cnt=0, state=GRANT.
  - Latency from req assertion to grant is 1 cycle.
- State GRANT (owner o):
  - Keep: req[o]=1 and (hold_cnt < MAX_HOLD-1 or no other req bit set). Grant unchanged. hold_cnt increments, saturating at MAX_HOLD-1.
  - Release: req[o]=0. ptr←o+1 mod N.
    - If other requests are pending, the winner is chosen from req in the new search order and granted next cycle, with no dead cycle.
    - Otherwise go to IDLE next cycle (grant=0).
  - Timeout: req[o]=1, hold_cnt=MAX_HOLD-1, and some other req set. ptr←o+1 mod N. Winner is chosen from req with bit o masked, granted next cycle.
- The owner's own request can never win a rotation decision made in the same cycle. A re-requesting former owner waits its round-robin turn.
- hold_cnt resets to 0 on every ownership change.
- MAX_HOLD=1: the owner is rotated every cycle whenever others request.
- A single requester holds indefinitely; the timeout applies only under contention.
- grant is always one-hot or zero, and sel always matches grant. No glitch on registered outputs; f follows d combinationally for the current owner.
- Requests dropping while not owner need no handshake; arbitration samples req only at the decision edge.

Test Plan:
- Reset: rst=1 with req=4'b1111 → grant=0, valid=0, f=0. After rst deasserts, grant=4'b0001, sel=0 one cycle later.
- Single requester: req=4'b0100 from IDLE, held 20 cycles → grant=4'b0100 from cycle 1 and stays through cycle 20; sel=2; f=d[2]. On drop, IDLE next cycle with grant=0.
- Round-robin: all req high, each owner drops req for one cycle after granting → grant sequence 0001, 0010, 0100, 1000, 0001 (wrap). No idle cycles between grants.
- Timeout, MAX_HOLD=8: req=4'b0011 held constant → requester0 granted 8 cycles, then requester1 for 8, then requester0. Each handover lands exactly at hold_cnt=7.
- Reset mid-grant: owner=3 with valid=1, rst pulsed between clock edges → grant=0 and f=0 immediately. After release, req=4'b1000 gives grant=4'b1000 (ptr back to 0).
- Data path, W=4: d={4'hD,4'hC,4'hB,4'hA}, owner 1 → f=4'hB. Idle → f=4'h0 regardless of d.
